// File: rtl/ysyx_23060096_mem_pkg.sv
// Shared definitions for the fetch-side instruction memory.
//   imem_state_t  : responder FSM encoding
//   DEFAULT_BASE  : default byte address of word 0
//   NOP_INST      : RV32I canonical NOP (addi x0,x0,0), handy for images
//   addr_misaligned() : word-alignment check on the low address bits
package ysyx_23060096_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  function automatic logic addr_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060096_imem_array.sv
// Synchronous word array, DEPTH x 32, one read port and one write port.
//   clk, rst          : clock; rst clears only the read-data register
//   rd_en, rd_idx     : read strobe and word index
//   rd_data           : registered read data, held until the next rd_en
//   wr_en, wr_idx,
//   wr_data           : write port (preload)
// A read and a write to the same index on one edge return the old word.
module ysyx_23060096_imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: accepts one fetch PC at a time and returns
// the instruction word LATENCY cycles after acceptance.
//   clk, rst              : clock, async active-high reset
//   req_valid/req_ready   : fetch request handshake, req_addr = byte PC
//   rsp_valid/rsp_ready   : response handshake
//   rsp_inst, rsp_err     : instruction word / misaligned-or-out-of-range flag
//   ld_en, ld_idx, ld_data: preload write port, active in any state
module ysyx_23060096_imem_resp
  import ysyx_23060096_mem_pkg::*;
#(
  parameter logic [31:0] BASE     = DEFAULT_BASE,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] ERR_INST = 32'h0000_0000,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);

  localparam int unsigned CW   = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  imem_state_t   state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx_q;
  logic          err_q;
  logic          rsp_err_q;
  logic          rsp_valid_q;
  logic          req_ready_q;

  logic [31:0]   off;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          accept;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;

  // Subtraction wraps, so PCs below BASE land far above SPAN.
  always_comb begin
    off     = req_addr - BASE;
    req_err = addr_misaligned(req_addr[1:0]) || ({1'b0, off} >= SPAN);
    req_idx = off[AW+1:2];
    accept  = req_valid && req_ready_q;
  end

  // The array is read on the edge that enters RESP. With LATENCY==1 that is
  // the acceptance edge itself, so the live index is used instead of idx_q.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = idx_q;
    if (state == IDLE) begin
      rd_idx = req_idx;
      rd_en  = (LATENCY == 1) && accept && !req_err;
    end else if (state == WAIT) begin
      rd_en  = (cnt == CW'(1)) && !err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q       <= req_idx;
            err_q       <= req_err;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state       <= RESP;
              cnt         <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  ysyx_23060096_imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_inst  = rsp_err_q ? ERR_INST : rd_data;

endmodule

// File: doc/ysyx_23060096_imem_resp.md
Name: ysyx_23060096_imem_resp

Overview:
Instruction-memory responder for the fetch side of the core.
- The core presents a fetch PC; this block returns the 32-bit instruction word after a fixed, programmable latency.
- It uses a valid/ready request/response handshake with one outstanding request.
- It sits between the PC/fetch stage and the decode stage, and replaces the ideal combinational instruction input.
- A side-band load port preloads program images from the bench or a boot loader.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; must be a power of two and at least 2.
- LATENCY, 2, cycles from request acceptance to the first rsp_valid cycle; must be at least 1.
- ERR_INST, 32'h0000_0000, value driven on rsp_inst for error responses.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, 1, fetch request valid.
- req_ready, output, 1, block can accept a request.
- req_addr, input, 32, fetch byte address (PC).
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_inst, output, 32, instruction word.
- rsp_err, output, 1, misaligned or out-of-range fetch.
- ld_en, input, 1, preload write enable.
- ld_idx, input, $clog2(DEPTH), preload word index.
- ld_data, input, 32, preload data.

Behaviour:
- Reset (async assert): state=IDLE; req_ready=1 once out of reset; rsp_valid=0; rsp_inst=0; rsp_err=0; latency counter=0.
- Memory contents are not reset.
- Reset mid-operation discards any in-flight request with no response.
- FSM state IDLE: req_ready=1.
  - Acceptance occurs when req_valid&&req_ready at edge N.
  - On acceptance: capture the address, compute error/index, and load counter=LATENCY-1.
  - If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- FSM state WAIT: req_ready=0; the counter decrements each cycle and the FSM goes to RESP when the counter reaches 0.
- Timing: rsp_valid rises in cycle N+LATENCY.
- Array read: occurs on the edge entering RESP, using the captured index.
  - A ld_en write to the same index on that same edge is not visible (read-before-write).
  - Earlier writes are visible.
- FSM state RESP: rsp_valid=1; rsp_inst and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On handshake: go to IDLE, with rsp_valid=0 the next cycle.
  - No back-to-back acceptance: req_ready is 0 in RESP, so the next acceptance is at the earliest in the cycle after the handshake.
- Error rules:
  - Misaligned: req_addr[1:0]!=0 -> rsp_err=1.
  - Out of range: (req_addr-BASE) >= DEPTH*4, evaluated with 32-bit unsigned wrap, so addresses below BASE are out of range -> rsp_err=1.
  - On error, rsp_inst=ERR_INST and the array is not read.
  - The error response still honours LATENCY and the handshake.
- Index: (req_addr-BASE)[$clog2(DEPTH)+1:2].
- Preload: ld_en writes mem[ld_idx]=ld_data on posedge in any state, independent of the FSM.
- req_addr is ignored while req_valid=0 or req_ready=0.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Shared package ysyx_23060096_mem_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the default BASE constant;
  - the NOP encoding 32'h0000_0013 for bench use.
- One natural sub-module is ysyx_23060096_imem_array: a synchronous single-read/single-write word array, DEPTH x 32, with read-before-write.
- The FSM, counter and address checks stay in the top.

Test Plan:
1. Preload mem[0]=32'h0010_0093 and mem[1]=32'h0020_0113; with LATENCY=2, request 0x8000_0000 at cycle N, rsp_ready=1 -> rsp_valid at N+2, rsp_inst=32'h0010_0093, rsp_err=0; next request 0x8000_0004 returns 32'h0020_0113.
2. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_inst and rsp_err stay stable and req_ready=0 throughout; raise rsp_ready -> one handshake, rsp_valid=0 next cycle.
3. Errors: request 0x8000_0002 -> rsp_err=1, rsp_inst=ERR_INST; request 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> rsp_err=1, still at N+LATENCY.
4. Preload collision: write mem[3]=0xDEAD_BEEF on the edge entering RESP for a fetch of 0x8000_000C whose old value is 0x1111_1111 -> rsp_inst=0x1111_1111; a refetch returns 0xDEAD_BEEF.
5. Reset mid-WAIT: assert rst asynchronously one cycle after acceptance -> rsp_valid=0 immediately, no response is produced, and req_ready=1 after deassertion.
6. LATENCY=1 build: back-to-back fetches with rsp_ready=1 -> one response every 2 cycles, in order, with correct data.
